// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes, flag layout,
// response bundle and the output buffer occupancy states.
package alu_pkg;

    localparam int ALU_DATA_W  = 64;
    localparam int ALU_SHAMT_W = 6;

    // ALU control codes as produced by the ALU control decoder
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_EOR   = 4'b1001;
    localparam logic [3:0] ALU_LSR   = 4'b1011;

    // Bit positions inside the 4-bit {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic [3:0]            flags;
        logic                  illegal;
    } alu_resp_t;

    // Occupancy of the main/skid pair; skid is only ever used when main is full
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_MAIN  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational compute stage: result, NZCV flags and illegal-code indication.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]             alu_ctl,
    input  logic [ALU_DATA_W-1:0]  op_a,
    input  logic [ALU_DATA_W-1:0]  op_b,
    input  logic [ALU_SHAMT_W-1:0] shamt,
    output alu_resp_t              resp
);

    logic [ALU_DATA_W-1:0] b_eff;
    logic                  carry_in;
    logic [ALU_DATA_W:0]   sum;
    logic [ALU_DATA_W-1:0] res;
    logic                  ill;
    logic                  arith;

    // Shared adder (SUB uses A + ~B + 1) and operation select
    always_comb begin
        carry_in = (alu_ctl == ALU_SUB);
        b_eff    = carry_in ? ~op_b : op_b;
        sum      = {1'b0, op_a} + {1'b0, b_eff} + {{ALU_DATA_W{1'b0}}, carry_in};
        res      = '0;
        ill      = 1'b0;
        arith    = 1'b0;
        case (alu_ctl)
            ALU_ADD, ALU_SUB: begin
                res   = sum[ALU_DATA_W-1:0];
                arith = 1'b1;
            end
            ALU_AND:   res = op_a & op_b;
            ALU_ORR:   res = op_a | op_b;
            ALU_EOR:   res = op_a ^ op_b;
            ALU_LSL:   res = op_a << shamt;
            ALU_LSR:   res = op_a >> shamt;
            ALU_PASSB: res = op_b;
            default:   ill = 1'b1;
        endcase
    end

    // Flags; C and V only carry meaning for the adder operations
    always_comb begin
        resp.result         = res;
        resp.illegal        = ill;
        resp.flags          = '0;
        resp.flags[FLAG_N]  = res[ALU_DATA_W-1];
        resp.flags[FLAG_Z]  = (res == '0);
        resp.flags[FLAG_C]  = arith & sum[ALU_DATA_W];
        resp.flags[FLAG_V]  = arith & (op_a[ALU_DATA_W-1] == b_eff[ALU_DATA_W-1])
                                    & (sum[ALU_DATA_W-1] != op_a[ALU_DATA_W-1]);
    end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU wrapper: registered result over valid/ready with a
// main + skid buffer so in_ready never depends combinationally on out_ready.
//
// state     | meaning
// ----------|-------------------------------------------------
// BUF_EMPTY | nothing held, out_valid=0, in_ready=1
// BUF_MAIN  | one op in main (on outputs), skid empty
// BUF_FULL  | main and skid both hold ops, in_ready=0
module ex_alu_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctl,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic [3:0]         flags,
    output logic               illegal
);

    buf_state_t state_q;
    buf_state_t state_d;
    alu_resp_t  core_resp;
    alu_resp_t  main_q;
    alu_resp_t  skid_q;
    logic       in_ready_q;
    logic       accept;
    logic       load_main;
    logic       load_skid;
    logic       move_skid;

    alu_core u_core (
        .alu_ctl (alu_ctl),
        .op_a    (op_a),
        .op_b    (op_b),
        .shamt   (shamt),
        .resp    (core_resp)
    );

    assign accept = in_valid && in_ready_q;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and which register loads on this edge
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = BUF_MAIN;
                end
            end
            BUF_MAIN: begin
                if (accept) begin
                    if (out_ready) begin
                        load_main = 1'b1;
                    end else begin
                        load_skid = 1'b1;
                        state_d   = BUF_FULL;
                    end
                end else if (out_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (out_ready) begin
                    move_skid = 1'b1;
                    state_d   = BUF_MAIN;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // Data registers; main keeps its last value after draining so outputs stay quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (load_main) begin
                main_q <= core_resp;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= core_resp;
            end
            in_ready_q <= (state_d != BUF_FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign result    = main_q.result;
    assign flags     = main_q.flags;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed corner cases, skid/stall
// scenario, mid-flight reset, then a randomized stream against a queue model.
module tb_ex_alu_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctl;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [5:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [3:0]  flags;
    logic        illegal;

    int n_cmp;
    int n_err;

    logic [68:0] exp_q[$];

    ex_alu_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {illegal, N Z C V, result}, derived from arithmetic meaning
    function automatic logic [68:0] model(input logic [3:0] ctl, input logic [63:0] a,
                                          input logic [63:0] b, input logic [5:0] sh);
        logic [63:0]        r;
        logic               c;
        logic               v;
        logic               ill;
        logic signed [65:0] exact;
        logic signed [65:0] wrapped;
        r = 64'd0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (ctl)
            4'b0010: begin
                r       = a + b;
                c       = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
                exact   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                wrapped = $signed({{2{r[63]}}, r});
                v       = (exact != wrapped);
            end
            4'b0110: begin
                r       = a - b;
                c       = (a >= b);
                exact   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                wrapped = $signed({{2{r[63]}}, r});
                v       = (exact != wrapped);
            end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1001: r = a ^ b;
            4'b0011: r = a << sh;
            4'b1011: r = a >> sh;
            4'b0111: r = b;
            default: ill = 1'b1;
        endcase
        return {ill, r[63], (r == 64'd0), c, v, r};
    endfunction

    task automatic do_op(input string tag, input logic [3:0] ctl, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] sh,
                         input logic [63:0] e_res, input logic [3:0] e_fl, input logic e_ill);
        @(negedge clk);
        in_valid  = 1'b1;
        alu_ctl   = ctl;
        op_a      = a;
        op_b      = b;
        shamt     = sh;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_res"}, result, e_res);
        chk({tag, "_nzcv"}, 64'(flags), 64'(e_fl));
        chk({tag, "_ill"}, 64'(illegal), 64'(e_ill));
    endtask

    task automatic present(input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        alu_ctl  = 4'b0010;
        op_a     = a;
        op_b     = b;
        shamt    = 6'd0;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [3:0] rnd_ctl();
        logic [3:0] codes [8];
        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0111};
        if ($urandom_range(0, 9) == 0) return 4'($urandom);
        return codes[$urandom_range(0, 7)];
    endfunction

    initial begin
        logic        hold;
        logic        stall_prev;
        logic [63:0] held_res;
        logic [4:0]  held_fl;
        logic [68:0] e;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; alu_ctl = 4'd0; op_a = '0; op_b = '0; shamt = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'({illegal, flags}), 64'd0);
        rst_n = 1'b1;

        // Directed corner cases
        do_op("add", 4'b0010, 64'd5, 64'd7, 6'd0, 64'd12, 4'b0000, 1'b0);
        do_op("sub_neg", 4'b0110, 64'd3, 64'd5, 6'd0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
        do_op("sub_eq", 4'b0110, 64'h10, 64'h10, 6'd0, 64'd0, 4'b0110, 1'b0);
        do_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0,
              64'h8000_0000_0000_0000, 4'b1001, 1'b0);
        do_op("lsl63", 4'b0011, 64'd1, 64'd0, 6'd63, 64'h8000_0000_0000_0000, 4'b1000, 1'b0);
        do_op("lsr63", 4'b1011, 64'h8000_0000_0000_0000, 64'd0, 6'd63, 64'd1, 4'b0000, 1'b0);
        do_op("passb0", 4'b0111, 64'd9, 64'd0, 6'd0, 64'd0, 4'b0100, 1'b0);
        do_op("illegal", 4'b1111, 64'd9, 64'd3, 6'd0, 64'd0, 4'b0100, 1'b1);

        // Back-to-back with downstream stalled after the first accept
        @(negedge clk);
        present(64'd1, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        present(64'd2, 64'd2);
        out_ready = 1'b0;
        @(negedge clk);
        chk("b2b_ready_full", 64'(in_ready), 64'd0);
        chk("b2b_first", result, 64'd2);
        present(64'd3, 64'd3);
        @(negedge clk);
        chk("b2b_held_off", 64'(in_ready), 64'd0);
        chk("b2b_stable", result, 64'd2);
        chk("b2b_stable_v", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_second", result, 64'd4);
        chk("b2b_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_third", result, 64'd6);
        chk("b2b_third_v", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("b2b_drained", 64'(out_valid), 64'd0);

        // Reset with both entries occupied
        present(64'd1, 64'd1);
        out_ready = 1'b0;
        @(negedge clk);
        present(64'd2, 64'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_before_rst", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 4'b0010, 64'd5, 64'd7, 6'd0, 64'd12, 4'b0000, 1'b0);

        // Randomized stream against the queue model
        hold = 1'b0;
        stall_prev = 1'b0;
        held_res = '0;
        held_fl = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_result", result, held_res);
                chk("stall_flags", 64'({illegal, flags}), 64'(held_fl));
            end
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                alu_ctl  = rnd_ctl();
                op_a     = rnd_operand();
                op_b     = rnd_operand();
                shamt    = 6'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_underflow", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_result", result, e[63:0]);
                    chk("rnd_flags", 64'({illegal, flags}), 64'(e[68:64]));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(alu_ctl, op_a, op_b, shamt));
            hold       = in_valid && !in_ready;
            stall_prev = out_valid && !out_ready;
            held_res   = result;
            held_fl    = {illegal, flags};
        end

        // Drain with a bounded budget
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && out_valid; cyc++) begin
            if (exp_q.size() == 0) begin
                chk("drain_underflow", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("drain_result", result, e[63:0]);
                chk("drain_flags", 64'({illegal, flags}), 64'(e[68:64]));
            end
            @(negedge clk);
        end
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage 64-bit LEGv8 ALU. It consumes the 4-bit ALU control code that the ALU control decoder produces, plus two operands and a shift amount.
- Returns a registered result and NZCV flags over a valid/ready handshake.
- Contains a 2-entry skid buffer, so in_ready is a pure register output and memory/writeback stalls do not form a combinational ready path back into decode.

Parameters:
- DATA_W, 64, operand/result width (shifts assume DATA_W = 64).
- SHAMT_W, 6, shift-amount width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept; registered.
- alu_ctl  input  4  ALU control code.
- op_a  input  DATA_W  operand A (Rn).
- op_b  input  DATA_W  operand B (Rm, immediate or address offset).
- shamt  input  SHAMT_W  shift amount for LSL/LSR.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- result  output  DATA_W  ALU result.
- flags  output  4  {N,Z,C,V}.
- illegal  output  1  alu_ctl was not a defined code.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - Reset values: in_ready=1, out_valid=0, result=0, flags=0, illegal=0. Both buffer entries are invalid.
- Decode of alu_ctl (combinational compute stage):
  - 0010 ADD: A+B.
  - 0110 SUB: A+~B+1.
  - 0000 AND: A&B.
  - 0001 ORR: A|B.
  - 1001 EOR: A^B.
  - 0011 LSL: A<<shamt.
  - 1011 LSR: A>>shamt, logical.
  - 0111 PASSB: B, used for CBZ/CBNZ zero test and BR target.
  - Any other code: result=0, illegal=1, flags computed from the 0 result.
- Flags:
  - N = result[DATA_W-1]; Z = (result==0).
  - C and V are meaningful for ADD/SUB only; they are 0 for every other code.
  - C = carry-out of the DATA_W+1-bit sum. For SUB, C=1 means no borrow.
  - V = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is B for ADD and ~B for SUB.
- Handshake:
  - A transfer occurs when valid&&ready on the same edge.
  - Producer holds alu_ctl/op_a/op_b/shamt stable while in_valid && !in_ready.
  - out_valid, once high, stays high until out_ready is sampled high. result, flags and illegal stay stable meanwhile.
- Latency and throughput:
  - Accepted operation appears on out_* the next cycle when the output is empty or draining.
  - Throughput is 1 op/cycle while out_ready=1.
- Buffer structure: main register (drives outputs) plus skid register.
- Cases on each edge:
  - Accept with main empty, or with main valid and out_ready=1: the new op loads main.
  - Accept with main valid and out_ready=0: the new op loads skid. in_ready goes 0 the next cycle.
  - Skid valid and out_ready=1: skid moves to main, skid clears, in_ready returns to 1.
  - in_ready = !skid_valid, registered. At most one op can be in skid; no accept is possible while skid is full.
  - Main valid, out_ready=1 and no accept: out_valid drops.
- Order is strictly FIFO. No op is dropped or duplicated.
- Reset mid-operation: both entries are discarded immediately (asynchronous). Outputs return to reset values.

Decomposition:
- Package alu_pkg:
  - ALU control code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_LSL, ALU_LSR, ALU_PASSB.
  - Flag bit indices.
  - Packed struct alu_resp_t {result, flags, illegal}.
  - The ALU control decoder imports the same constants.
- Sub-module alu_core: purely combinational compute of result, flags and illegal from alu_ctl/op_a/op_b/shamt.
- Top-level ex_alu_unit owns the skid/handshake logic only.

Test Plan:
- Reset, then ADD with A=5, B=7, out_ready=1 -> next cycle out_valid=1, result=12, flags=0000, illegal=0.
- SUB with A=3, B=5 -> result=0xFFFFFFFFFFFFFFFE, N=1, Z=0, C=0, V=0. SUB with A=B=0x10 -> Z=1, C=1.
- ADD with A=0x7FFFFFFFFFFFFFFF, B=1 -> result=0x8000000000000000, N=1, V=1, C=0.
- LSL with A=1, shamt=63 -> result=0x8000000000000000. LSR with A=0x8000000000000000, shamt=63 -> result=1. PASSB with B=0 -> Z=1. alu_ctl=1111 -> result=0, illegal=1, Z=1.
- Back-to-back stream:
  - Stimulus: ops ADD(1,1), ADD(2,2), ADD(3,3) with out_ready held 0 after the first accept.
  - Expected: in_ready=0 after the second accept, and the third op is held off.
  - Release out_ready: results 2, 4, 6 come out in order, with no drop or duplicate and out_* stable while stalled.
- Assert rst_n low while both entries are valid -> out_valid=0 and in_ready=1 immediately. After release the first new op emerges with 1-cycle latency.
